// File: rtl/pe_seq_ctrl.sv
// Micro-op sequencer for one PE: turns a "compute one output pixel" command into
// N MAC cycles, a bias+output cycle and a flush, gated by the operand feeder handshake.
module pe_seq_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_mac,
  input  logic              cfg_relu,
  input  logic              abort,
  input  logic              op_valid,
  output logic              op_ready,
  output logic              in_valid,
  output logic              calc_bias,
  output logic              out_en,
  output logic              calc_relu,
  output logic              flush,
  input  logic [DATA_W-1:0] result_r,
  input  logic              out_valid_r,
  input  logic              illegal_uop,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_BIAS, S_FLUSH, S_WAIT, S_DONE, S_ERR, S_ABORT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_num_mac;
  logic               r_relu;
  logic               r_seen_out;
  logic [TMO_W-1:0]   r_tmo;
  logic [DATA_W-1:0]  r_res;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_can_abort;
  logic               w_err_src;
  logic               w_out_state;

  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_can_abort = (r_state != S_IDLE) && (r_state != S_ABORT);
  assign w_err_src   = (r_state == S_MAC) || (r_state == S_BIAS) ||
                       (r_state == S_FLUSH) || (r_state == S_WAIT);
  assign w_out_state = (r_state == S_BIAS) || (r_state == S_FLUSH) || (r_state == S_WAIT);

  // State, counters and result latch; abort beats illegal_uop beats normal progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_num_mac  <= '0;
      r_relu     <= 1'b0;
      r_seen_out <= 1'b0;
      r_tmo      <= '0;
      r_res      <= '0;
    end else begin
      if (out_valid_r && (r_state != S_IDLE)) r_res <= result_r;
      if (out_valid_r && w_out_state) r_seen_out <= 1'b1;

      if (w_can_abort && abort) begin
        r_state <= S_ABORT;
      end else if (w_err_src && illegal_uop) begin
        r_state <= S_ERR;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_num_mac  <= cfg_num_mac;
              r_relu     <= cfg_relu;
              r_cnt      <= '0;
              r_seen_out <= 1'b0;
              r_state    <= (cfg_num_mac != '0) ? S_MAC : S_BIAS;
            end
          end
          S_MAC: begin
            if (op_valid) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == r_num_mac) r_state <= S_BIAS;
            end
          end
          S_BIAS: begin
            if (op_valid) r_state <= S_FLUSH;
          end
          S_FLUSH: begin
            r_tmo   <= '0;
            r_state <= (r_seen_out || out_valid_r) ? S_DONE : S_WAIT;
          end
          S_WAIT: begin
            if (out_valid_r) begin
              r_state <= S_DONE;
            end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
              r_state <= S_ERR;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          S_ERR:   r_state <= S_ERR;
          S_ABORT: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // PE micro-op decode; bias/out_en only ever accompany in_valid.
  always_comb begin
    op_ready  = 1'b0;
    in_valid  = 1'b0;
    calc_bias = 1'b0;
    out_en    = 1'b0;
    calc_relu = 1'b0;
    flush     = 1'b0;
    case (r_state)
      S_MAC: begin
        op_ready = 1'b1;
        in_valid = op_valid;
      end
      S_BIAS: begin
        op_ready  = 1'b1;
        in_valid  = op_valid;
        calc_bias = op_valid;
        out_en    = op_valid;
        calc_relu = op_valid & r_relu;
      end
      S_FLUSH, S_ABORT: flush = 1'b1;
      default: ;
    endcase
  end

  assign res_data = r_res;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);

endmodule
